// File: rtl/uart_bus_bridge_pkg.sv
// uart_bus_bridge_pkg: FSM states and host command/response byte codes shared by the UART bus bridge
package uart_bus_bridge_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_BUS_REQ, S_BUS_ACCESS, S_BUS_WAIT, S_SEND
  } state_t;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h06;
  localparam logic [7:0] RSP_NAK   = 8'h15;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver; after a start edge it samples the line once per baud_pulse
module uart_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       baud_pulse,
  output logic       uart_rx_done,
  output logic [7:0] rx_data
);
  logic [1:0] sync;
  logic [3:0] idx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= 2'b11;
      idx <= '0;
      rx_data <= '0;
      uart_rx_done <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      uart_rx_done <= 1'b0;
      if (idx == 4'd0) begin
        if (!sync[1]) idx <= 4'd1;
      end else if (baud_pulse) begin
        if (idx == 4'd1) idx <= sync[1] ? 4'd0 : 4'd2;
        else if (idx == 4'd10) begin
          idx <= 4'd0;
          uart_rx_done <= sync[1];
        end else begin
          rx_data <= {sync[1], rx_data[7:1]};
          idx <= idx + 4'd1;
        end
      end
    end
  end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter; starts a byte on a baud_pulse while tx_start is high, pulses uart_tx_done after the stop bit
module uart_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic       baud_pulse,
  input  logic [7:0] tx_data,
  output logic       uart_tx_done,
  output logic       tx
);
  logic [9:0] sh;
  logic [3:0] idx;
  assign tx = sh[0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '1;
      idx <= '0;
      uart_tx_done <= 1'b0;
    end else begin
      uart_tx_done <= 1'b0;
      if (baud_pulse) begin
        if (idx == 4'd0) begin
          if (tx_start) begin
            sh <= {1'b1, tx_data, 1'b0};
            idx <= 4'd1;
          end
        end else if (idx == 4'd10) begin
          idx <= 4'd0;
          uart_tx_done <= 1'b1;
        end else begin
          sh <= {1'b1, sh[9:1]};
          idx <= idx + 4'd1;
        end
      end
    end
  end
endmodule

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: UART-commanded single-word IO bus master; UART_BRIDGE_TIMEOUT_EN adds an inter-byte frame timeout
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int BAUD_DIVISOR = 650,
  parameter int RD_LATENCY   = 1
`ifdef UART_BRIDGE_TIMEOUT_EN
  , parameter int TIMEOUT_TICKS = 40
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        io_bus_m_req,
  input  logic        io_bus_m_gnt,
  output logic        io_bus_m_rd_en,
  output logic        io_bus_m_wr_en,
  output logic [31:0] io_bus_m_address,
  output logic [31:0] io_bus_m_wr_data,
  input  logic [31:0] io_bus_m_rd_data,
  output logic        busy
);
  localparam int BW = $clog2(BAUD_DIVISOR + 1);
  state_t state;
  logic [BW-1:0] baud_cnt;
  logic baud_pulse, rx_done, tx_done, tx_start, is_wr;
  logic [7:0] rx_data, lat;
  logic [1:0] nbyte, ntx;
  logic [31:0] rsp;
`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [15:0] tmo;
`endif
  assign baud_pulse = baud_cnt == BW'(1);
  uart_rx u_rx (.clk, .rst, .rx(uart_rx), .baud_pulse, .uart_rx_done(rx_done), .rx_data);
  uart_tx u_tx (.clk, .rst, .tx_start, .baud_pulse, .tx_data(rsp[7:0]), .uart_tx_done(tx_done), .tx(uart_tx));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) baud_cnt <= '0;
    else baud_cnt <= (baud_cnt == BW'(BAUD_DIVISOR)) ? '0 : baud_cnt + BW'(1);
  end
  // Responses go out LSB-first from rsp; each completed byte shifts the next one into place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      {io_bus_m_req, io_bus_m_rd_en, io_bus_m_wr_en, busy, tx_start, is_wr} <= '0;
      {io_bus_m_address, io_bus_m_wr_data, rsp} <= '0;
      {nbyte, ntx, lat} <= '0;
`ifdef UART_BRIDGE_TIMEOUT_EN
      tmo <= '0;
`endif
    end else begin
      io_bus_m_rd_en <= 1'b0;
      io_bus_m_wr_en <= 1'b0;
      case (state)
        S_IDLE: if (rx_done) begin
          busy <= 1'b1;
          nbyte <= 2'd0;
          is_wr <= rx_data == CMD_WRITE;
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) state <= S_GET_ADDR;
          else begin
            rsp <= {24'h0, RSP_NAK};
            ntx <= 2'd0;
            tx_start <= 1'b1;
            state <= S_SEND;
          end
        end
        S_GET_ADDR: if (rx_done) begin
          io_bus_m_address <= {rx_data, io_bus_m_address[31:8]};
          nbyte <= nbyte + 2'd1;
          if (nbyte == 2'd3) begin
            state <= is_wr ? S_GET_DATA : S_BUS_REQ;
            io_bus_m_req <= !is_wr;
          end
        end
        S_GET_DATA: if (rx_done) begin
          io_bus_m_wr_data <= {rx_data, io_bus_m_wr_data[31:8]};
          nbyte <= nbyte + 2'd1;
          if (nbyte == 2'd3) begin
            state <= S_BUS_REQ;
            io_bus_m_req <= 1'b1;
          end
        end
        S_BUS_REQ: if (io_bus_m_gnt) begin
          state <= S_BUS_ACCESS;
          io_bus_m_rd_en <= !is_wr;
          io_bus_m_wr_en <= is_wr;
        end
        S_BUS_ACCESS: begin
          io_bus_m_req <= 1'b0;
          lat <= 8'd1;
          rsp <= {24'h0, RSP_ACK};
          ntx <= 2'd0;
          tx_start <= is_wr;
          state <= is_wr ? S_SEND : S_BUS_WAIT;
        end
        S_BUS_WAIT: if (lat == 8'(RD_LATENCY)) begin
          rsp <= io_bus_m_rd_data;
          ntx <= 2'd3;
          tx_start <= 1'b1;
          state <= S_SEND;
        end else lat <= lat + 8'd1;
        S_SEND: if (tx_done) begin
          if (ntx == 2'd0) begin
            state <= S_IDLE;
            tx_start <= 1'b0;
            busy <= 1'b0;
          end else begin
            ntx <= ntx - 2'd1;
            rsp <= {8'h0, rsp[31:8]};
          end
        end
        default: state <= S_IDLE;
      endcase
`ifdef UART_BRIDGE_TIMEOUT_EN
      if ((state == S_GET_ADDR || state == S_GET_DATA) && !rx_done) begin
        if (tmo == 16'(TIMEOUT_TICKS)) begin
          rsp <= {24'h0, RSP_NAK};
          ntx <= 2'd0;
          tx_start <= 1'b1;
          state <= S_SEND;
          tmo <= '0;
        end else if (baud_pulse) tmo <= tmo + 16'd1;
      end else tmo <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge: directed host-frame scenarios for uart_bus_bridge with a UART host model and bus responder
module tb_uart_bus_bridge;
  localparam int BD = 15;
  localparam int BP = BD + 1;
  logic clk = 0, rst = 1, uart_rx = 1, gnt = 0;
  logic uart_tx, req, rd_en, wr_en, busy;
  logic [31:0] address, wr_data, rd_data;
  logic [31:0] mem_val = 0, last_waddr = 0, last_raddr = 0, last_wdata = 0;
  int n_wr = 0, n_rd = 0, no_req = 0, checks = 0, errors = 0, tbc = 0;
  logic [7:0] rxq[$];

  always #5 clk = ~clk;

  uart_bus_bridge #(.BAUD_DIVISOR(BD), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .io_bus_m_req(req), .io_bus_m_gnt(gnt), .io_bus_m_rd_en(rd_en), .io_bus_m_wr_en(wr_en),
    .io_bus_m_address(address), .io_bus_m_wr_data(wr_data), .io_bus_m_rd_data(rd_data), .busy(busy)
  );

  // Host clock is phase-locked to the bridge's baud counter; bits change mid-way between sample pulses.
  always @(posedge clk or posedge rst) begin
    if (rst) tbc <= 0;
    else tbc <= (tbc == BD) ? 0 : tbc + 1;
  end

  always @(posedge clk) begin
    rd_data <= rd_en ? mem_val : 32'hBAD0BAD0;
    if (!rst && wr_en) begin n_wr++; last_waddr = address; last_wdata = wr_data; if (!req) no_req++; end
    if (!rst && rd_en) begin n_rd++; last_raddr = address; if (!req) no_req++; end
  end

  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        repeat (BP / 2) @(negedge clk);
        if (uart_tx === 1'b0) begin
          for (int i = 0; i < 8; i++) begin repeat (BP) @(negedge clk); b[i] = uart_tx; end
          repeat (BP) @(negedge clk);
          if (uart_tx === 1'b1) rxq.push_back(b);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] v);
    logic [9:0] f;
    f = {1'b1, v, 1'b0};
    for (int i = 0; i < 10; i++) begin
      do @(negedge clk); while (tbc != 9);
      uart_rx = f[i];
    end
  endtask

  // Bytes are listed first-sent first: f holds n bytes with the first one most significant.
  task automatic send_frame(input logic [71:0] f, input int n);
    for (int i = 0; i < n; i++) send_byte(f[8*(n-1-i) +: 8]);
  endtask

  task automatic wait_rx(input int n, output bit ok);
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      if (rxq.size() >= n) ok = 1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (busy === 1'b0) ok = 1;
      else @(negedge clk);
    end
  endtask

  function automatic logic [31:0] rx_word();
    return (rxq.size() >= 4) ? {rxq[3], rxq[2], rxq[1], rxq[0]} : 32'hxxxxxxxx;
  endfunction

  function automatic logic [7:0] rx_first();
    return (rxq.size() >= 1) ? rxq[0] : 8'hxx;
  endfunction

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
    checks++; if ({rd_en, wr_en} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {rd_en, wr_en}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (address !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", address); end
    checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wr_data); end
    rst = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write;
    int w0, r0;
    bit ok;
    w0 = n_wr; r0 = n_rd; gnt = 1; rxq.delete();
    send_frame(72'({8'h57, 8'h00, 8'h10, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE}), 9);
    wait_rx(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL write_rsp_wait: got %0d bytes want 1", rxq.size()); end
    checks++; if (rx_first() !== 8'h06) begin errors++; $display("FAIL write_ack: got %h want 06", rx_first()); end
    checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL write_count: got %0d want 1", n_wr - w0); end
    checks++; if (last_waddr !== 32'h80001000) begin errors++; $display("FAIL write_addr: got %h want 80001000", last_waddr); end
    checks++; if (last_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data: got %h want deadbeef", last_wdata); end
    checks++; if (n_rd !== r0) begin errors++; $display("FAIL write_no_read: got %0d reads want 0", n_rd - r0); end
    wait_idle(ok);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL write_busy: got %b want 0", busy); end
    checks++; if (no_req !== 0) begin errors++; $display("FAIL write_strobe_req: got %0d strobes without req want 0", no_req); end
  endtask

  task automatic test_read;
    int w0, r0;
    bit ok;
    w0 = n_wr; r0 = n_rd; rxq.delete(); mem_val = 32'h12345678;
    send_frame(72'({8'h52, 8'h04, 8'h00, 8'h00, 8'h80}), 5);
    wait_rx(4, ok);
    checks++; if (rx_word() !== 32'h12345678) begin errors++; $display("FAIL read_data: got %h want 12345678", rx_word()); end
    checks++; if (n_rd - r0 !== 1) begin errors++; $display("FAIL read_count: got %0d want 1", n_rd - r0); end
    checks++; if (last_raddr !== 32'h80000004) begin errors++; $display("FAIL read_addr: got %h want 80000004", last_raddr); end
    checks++; if (n_wr !== w0) begin errors++; $display("FAIL read_no_write: got %0d writes want 0", n_wr - w0); end
    wait_idle(ok);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy: got %b want 0", busy); end
  endtask

  task automatic test_nak;
    int w0, r0;
    bit ok;
    w0 = n_wr; r0 = n_rd; rxq.delete();
    send_byte(8'h41);
    wait_rx(1, ok);
    checks++; if (rx_first() !== 8'h15) begin errors++; $display("FAIL nak_byte: got %h want 15", rx_first()); end
    checks++; if (n_wr + n_rd !== w0 + r0) begin errors++; $display("FAIL nak_no_bus: got %0d accesses want 0", n_wr + n_rd - w0 - r0); end
    wait_idle(ok);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nak_busy: got %b want 0", busy); end
  endtask

  task automatic test_gnt_withheld;
    int w0, viol;
    bit ok;
    w0 = n_wr; viol = 0; gnt = 0; rxq.delete();
    send_frame(72'({8'h57, 8'h20, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'hA5, 8'hA5}), 9);
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin if (req === 1'b1) ok = 1; else @(negedge clk); end
    checks++; if (!ok) begin errors++; $display("FAIL gnt_req_rise: got req=%b want 1", req); end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req !== 1'b1 || wr_en !== 1'b0 || rd_en !== 1'b0) viol++;
    end
    checks++; if (viol !== 0) begin errors++; $display("FAIL gnt_hold: got %0d bad cycles want 0", viol); end
    checks++; if (n_wr !== w0) begin errors++; $display("FAIL gnt_no_write: got %0d writes want 0", n_wr - w0); end
    gnt = 1;
    wait_rx(1, ok);
    checks++; if (rx_first() !== 8'h06) begin errors++; $display("FAIL gnt_ack: got %h want 06", rx_first()); end
    checks++; if (n_wr - w0 !== 1) begin errors++; $display("FAIL gnt_write_count: got %0d want 1", n_wr - w0); end
    checks++; if (last_waddr !== 32'h00000020) begin errors++; $display("FAIL gnt_addr: got %h want 00000020", last_waddr); end
    checks++; if (last_wdata !== 32'hA5A50001) begin errors++; $display("FAIL gnt_data: got %h want a5a50001", last_wdata); end
    wait_idle(ok);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL gnt_req_drop: got %b want 0", req); end
  endtask

  task automatic test_reset_midframe;
    int r0;
    bit ok;
    r0 = n_rd; rxq.delete();
    send_frame(72'({8'h52, 8'h04, 8'h00}), 3);
    repeat (2 * BP) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midframe_busy: got %b want 1", busy); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++; if ({busy, req, uart_tx} !== 3'b001) begin errors++; $display("FAIL midframe_reset: got busy/req/tx %b want 001", {busy, req, uart_tx}); end
    mem_val = 32'hCAFEF00D;
    send_frame(72'({8'h52, 8'h08, 8'h00, 8'h00, 8'h00}), 5);
    wait_rx(4, ok);
    checks++; if (rx_word() !== 32'hCAFEF00D) begin errors++; $display("FAIL midframe_data: got %h want cafef00d", rx_word()); end
    checks++; if (last_raddr !== 32'h00000008) begin errors++; $display("FAIL midframe_addr: got %h want 00000008", last_raddr); end
    checks++; if (n_rd - r0 !== 1) begin errors++; $display("FAIL midframe_count: got %0d want 1", n_rd - r0); end
    wait_idle(ok);
  endtask

`ifdef UART_BRIDGE_TIMEOUT_EN
  task automatic test_timeout;
    int r0;
    bit ok;
    r0 = n_rd; rxq.delete();
    send_frame(72'({8'h52, 8'h04}), 2);
    wait_rx(1, ok);
    checks++; if (rx_first() !== 8'h15) begin errors++; $display("FAIL timeout_nak: got %h want 15", rx_first()); end
    checks++; if (n_rd !== r0) begin errors++; $display("FAIL timeout_no_read: got %0d reads want 0", n_rd - r0); end
    wait_idle(ok);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got %b want 0", busy); end
  endtask
`else
  task automatic test_partial_wait;
    int r0;
    bit ok;
    r0 = n_rd; rxq.delete();
    send_frame(72'({8'h52, 8'h04}), 2);
    repeat (1200) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy: got %b want 1", busy); end
    checks++; if (rxq.size() !== 0) begin errors++; $display("FAIL partial_silent: got %0d bytes want 0", rxq.size()); end
    mem_val = 32'h0BADCAFE;
    send_frame(72'({8'h00, 8'h00, 8'h00}), 3);
    wait_rx(4, ok);
    checks++; if (rx_word() !== 32'h0BADCAFE) begin errors++; $display("FAIL partial_data: got %h want 0badcafe", rx_word()); end
    checks++; if (last_raddr !== 32'h00000004) begin errors++; $display("FAIL partial_addr: got %h want 00000004", last_raddr); end
    checks++; if (n_rd - r0 !== 1) begin errors++; $display("FAIL partial_count: got %0d want 1", n_rd - r0); end
    wait_idle(ok);
  endtask
`endif

  initial begin
    test_reset;
    test_write;
    test_read;
    test_nak;
    test_gnt_withheld;
    test_reset_midframe;
`ifdef UART_BRIDGE_TIMEOUT_EN
    test_timeout;
`else
    test_partial_wait;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Debug/loader bus master driven from a host over UART; the initiator counterpart to the memory-mapped UART slave.
- Parses byte commands from the host, issues single 32-bit read/write transactions on the IO interconnect after arbitration, and returns results over UART.
- Sits beside the CPU as a second IO-bus master, behind the interconnect arbiter.

Parameters:
- BAUD_DIVISOR, 650, baud counter terminal value; 650 gives 9600 baud.
- RD_LATENCY, 1, cycles from the read strobe to a valid io_bus_m_rd_data.
- TIMEOUT_TICKS, 40, baud pulses allowed between bytes of one frame (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- uart_rx  in  1  serial input from host
- uart_tx  out  1  serial output to host; idle high
- io_bus_m_req  out  1  bus request to arbiter
- io_bus_m_gnt  in  1  arbiter grant
- io_bus_m_rd_en  out  1  single-cycle read strobe
- io_bus_m_wr_en  out  1  single-cycle write strobe
- io_bus_m_address  out  32  transaction address
- io_bus_m_wr_data  out  32  write data
- io_bus_m_rd_data  in  32  read data, valid RD_LATENCY cycles after the rd_en cycle
- busy  out  1  high whenever the FSM is not IDLE

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-high (rst). All outputs 0 except uart_tx=1. FSM enters IDLE; byte counter, baud counter and shift registers are cleared. Reset mid-frame or mid-transaction aborts with no response. A bus strobe is never left asserted.
- Baud: counter runs 0..BAUD_DIVISOR, then wraps to 0; baud_pulse is high when count==1. This pulse feeds both byte engines.
- Frame format:
  - Command byte: 0x57 'W' or 0x52 'R'.
  - Then 4 address bytes, little-endian.
  - 'W' only: then 4 data bytes, little-endian.
- Responses:
  - 'W': one byte 0x06 (ACK).
  - 'R': 4 read-data bytes, little-endian.
  - Any other command byte: 0x15 (NAK), then return to IDLE.
- FSM transitions:
  - IDLE: on rx_done, 'W'/'R' -> GET_ADDR; any other byte -> SEND (NAK).
  - GET_ADDR: after 4 bytes, 'R' -> BUS_REQ; 'W' -> GET_DATA.
  - GET_DATA: after 4 bytes -> BUS_REQ.
  - BUS_REQ: io_bus_m_req held high until io_bus_m_gnt is sampled high -> BUS_ACCESS.
  - BUS_ACCESS: exactly one cycle. req stays high, the matching strobe is high, address/wr_data are stable. Then -> BUS_WAIT (read) or SEND (write). req drops after this cycle.
  - BUS_WAIT: counts RD_LATENCY cycles, captures io_bus_m_rd_data on the last one -> SEND.
  - SEND: tx_start held high with tx_data stable. On each uart_tx_done the byte index advances and tx_data updates on the next cycle. After the last byte -> IDLE.
- address and wr_data only change in GET_ADDR/GET_DATA; they are held from BUS_REQ through end of SEND.
- A byte received outside IDLE/GET_ADDR/GET_DATA is dropped. No FIFO, no overrun flag.
- Gnt arriving before req is ignored. Gnt deasserted while in BUS_REQ keeps the FSM waiting.
- Address bytes are unconstrained; alignment is the bus's concern.

Optional Feature:
- Macro: UART_BRIDGE_TIMEOUT_EN.
- Defined: inside GET_ADDR/GET_DATA, a counter of baud pulses resets on every rx_done. When it reaches TIMEOUT_TICKS, the frame is abandoned: no bus access occurs, NAK 0x15 is sent, then IDLE.
- Undefined: no timeout, and a partial frame waits indefinitely.

Decomposition:
- Shared package entries: FSM state enum, command codes (CMD_WRITE=8'h57, CMD_READ=8'h52), response codes (RSP_ACK=8'h06, RSP_NAK=8'h15).
- Sub-modules: instantiate the existing uart_rx (rx, baud_pulse -> uart_rx_done, rx_data) and uart_tx (tx_start, baud_pulse, tx_data -> uart_tx_done, tx). The bridge itself holds only the baud counter, FSM, shift registers and bus sequencing.

Test Plan:
- Write 57 00 10 00 80 EF BE AD DE, gnt tied high -> one wr_en cycle with address 0x80001000, wr_data 0xDEADBEEF; uart_tx sends 0x06; busy returns to 0.
- Read 52 04 00 00 80, with rd_data=0x12345678 one cycle after rd_en -> rd_en pulses once; uart_tx sends 78 56 34 12.
- Command byte 0x41 -> no bus activity; NAK 0x15 sent.
- Gnt withheld 100 cycles after a complete write frame -> req held high, no strobe until gnt; exactly one wr_en after grant.
- rst asserted after 2 address bytes, then a full read frame -> first frame discarded; second completes normally.
- With UART_BRIDGE_TIMEOUT_EN, send 52 04 then go silent > TIMEOUT_TICKS -> NAK 0x15, no rd_en, FSM in IDLE.
